// File: rtl/matrix_pkg.sv
// Shared definitions for the 5x5 matrix line permutation blocks.
package matrix_pkg;
  localparam int MAT_DIM = 5;
  localparam int LINE_W  = 25;
  localparam int IDX_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Forward map P: bit i of the source lands on bit P(i) of the encoded line.
  // Coordinates are recentred by +3, rotated/sheared, then shifted back by -3
  // (written as +2 to stay non-negative).
  function automatic logic [IDX_W-1:0] pi_fwd(input logic [IDX_W-1:0] idx);
    int x, y, xs, ys, nx, ny;
    x  = int'(idx) % MAT_DIM;
    y  = int'(idx) / MAT_DIM;
    xs = (x + 3) % MAT_DIM;
    ys = (y + 3) % MAT_DIM;
    nx = (ys + 2) % MAT_DIM;
    ny = ((2 * xs + 3 * ys) % MAT_DIM + 2) % MAT_DIM;
    return IDX_W'(MAT_DIM * ny + nx);
  endfunction
endpackage

// File: rtl/pi_index_rom.sv
// Combinational P(i) lookup; indices beyond the line width read as 0.
module pi_index_rom
  import matrix_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic [IDX_W-1:0] pidx_o
);

  logic [IDX_W-1:0] rom_w [LINE_W];

  // Table entries are constant-folded from the package map.
  for (genvar i = 0; i < LINE_W; i++) begin : g_rom
    assign rom_w[i] = pi_fwd(IDX_W'(i));
  end

  // Guard the unreachable 25..31 range so the lookup never leaves the table.
  always_comb begin
    pidx_o = '0;
    if (idx_i < IDX_W'(LINE_W)) pidx_o = rom_w[idx_i];
  end

endmodule

// File: rtl/matrix_decoder.sv
// Bit-serial inverse of the matrix permutation: one output bit per cycle,
// ROUNDS full passes per accepted line, result held until consumed.
module matrix_decoder
  import matrix_pkg::*;
#(
  parameter int ROUNDS = 1,   // 1..31
  parameter int N      = 25   // must be 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LINE_W - 1);
  localparam logic [4:0]       LAST_ROUND = 5'(ROUNDS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [4:0]         round_q, round_d;
  logic [N-1:0]       src_q, src_d;
  logic [N-1:0]       dst_q, dst_d;
  logic [IDX_W-1:0]   pidx;
  logic [N-1:0]       dst_upd;

  pi_index_rom u_rom (
    .idx_i  (idx_q),
    .pidx_o (pidx)
  );

  // dst with the current bit filled in; also feeds src when chaining passes.
  always_comb begin
    dst_upd        = dst_q;
    dst_upd[idx_q] = src_q[pidx];
  end

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign out_data  = dst_q;

  // Next-state: accept, step through the bits, chain rounds, hand off result.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    round_d = round_q;
    src_d   = src_q;
    dst_d   = dst_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d   = in_data;
          idx_d   = '0;
          round_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        dst_d = dst_upd;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (round_q == LAST_ROUND) begin
            state_d = DONE;
          end else begin
            src_d   = dst_upd;
            round_d = round_q + 5'd1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            src_d   = in_data;
            idx_d   = '0;
            round_d = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      round_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      round_q <= round_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

endmodule
